bp_lce_req_queued: RTL and testbench
====================================

// Module: bp_lce_req_queued
// PURPOSE
//  Next-gen LCE request issuer. Buffers up to reqs_p cache requests (miss/uncached)
//  in an in-order queue, pairs cached misses with their late-arriving metadata and
//  issues LCE->CCE requests under an outstanding-credit limit. Adds an uncached LCE
//  mode that converts misses to uncached requests. Sits between a cache and the coh NoC.
// PARAMETERS
//  bp_params_p      e_bp_inv_cfg            processor config (widths, coh_noc_max_credits_p)
//  assoc_p/sets_p   "inv"                   cache geometry
//  block_width_p    "inv"                   cache block bits; cached req size = block bytes (8..128)
//  reqs_p           2                       request queue depth (>=1)
//  credits_p        coh_noc_max_credits_p   max outstanding LCE requests (>=1)
//  non_excl_reads_p 0                       1: load misses request non-exclusive
// PORTS
//  clk_i                    in   1      clock
//  reset_n_i                in   1      synchronous reset, active-low
//  lce_id_i                 in   lce_id_width_p  source id in every header
//  lce_mode_i               in   bp_lce_mode_e   e_lce_mode_uncached: misses issue as uncached
//  ready_o                  out  1      may accept cache_req_v_i this cycle
//  cache_req_i/_v_i         in   bp_cache_req_s/1  request; accepted when ready_o & v_i
//  cache_req_metadata_i/_v_i in  metadata_s/1  hit_or_repl_way for newest cached entry
//  credits_full_o           out  1      count == credits_p
//  credits_empty_o          out  1      count == 0
//  cache_req_complete_i     in   1      one credit returned (cached / uc load)
//  uc_store_req_complete_i  in   1      one credit returned (uc store)
//  lce_req_o/_v_o           out  bp_lce_cce_req_s/1  request out, valid->ready
//  lce_req_ready_i          in   1      consumer accepts when v_o & ready_i
// BEHAVIOUR
//  - Reset (reset_n_i=0): queue emptied, count=0, state=e_reset; ready_o=0, lce_req_v_o=0,
//    credits_empty_o=1, credits_full_o=0. Reset mid-transfer drops all queued requests.
//  - FSM (head = oldest entry): e_reset -> e_ready after 1 cycle.
//    e_ready: head valid & needs metadata missing -> e_wait_meta; credits full -> e_wait_credit;
//    else lce_req_v_o=1. e_wait_meta -> e_ready when head meta valid (incl. same-cycle arrival:
//    issues next cycle). e_wait_credit -> e_ready on count < credits_p.
//  - Enqueue: ready_o = ~reset & state!=e_reset & queue not full & no entry awaiting metadata.
//    Full and dequeue same cycle: ready_o stays 0 (no bypass). Accept-to-issue latency >= 1 cycle.
//  - Metadata: latched into newest cached entry lacking it; may arrive same cycle as req or later.
//    metadata_v_i with no such entry is ignored. Entries of uc type / uncached mode need none.
//  - Header: src_id=lce_id_i, dst_id=bp_me_addr_to_cce_id(addr), addr=req addr.
//    miss_load: e_lce_req_type_rd, excl unless non_excl_reads_p; miss_store: e_lce_req_type_wr, excl;
//    both size=block size, lru_way_id=meta way. uc_load: uc_rd, size=req size.
//    uc_store: uc_wr, size=req size, data[63:0]=req data. Uncached mode (sampled at enqueue):
//    miss_load->uc_rd, miss_store->uc_wr with req size/data, no metadata wait.
//  - lce_req_v_o/lce_req_o stable until handshake; valid never depends on lce_req_ready_i.
//  - Credits: count += (v_o & ready_i) - cache_req_complete_i - uc_store_req_complete_i;
//    both completes same cycle subtract 2; send + return same cycle nets. Return at 0
//    saturates at 0 (assertion error). Issue blocked when count==credits_p.
// TESTING
//  1 reset_n_i low 3 cycles -> ready_o=0,v_o=0,empty=1; release -> ready_o=1 on 2nd cycle.
//  2 miss_load addr 0x8000_0040, meta way 3 two cycles later -> one rd, excl, lru_way 3,
//    size=block, issued cycle after meta; count 0->1; cache_req_complete_i -> count 0.
//  3 credits_p=2: three uc_load back-to-back, ready_i=1 -> two sent, third held in e_wait_credit
//    until a complete; full=1 while count=2.
//  4 uc_store data 0xDEAD_BEEF size 4, ready_i low 5 cycles -> v_o held, header stable, one send.
//  5 lce_mode_i uncached, miss_store -> uc_wr with no metadata; both complete inputs same
//    cycle at count 2 -> count 0, empty=1.
//  6 reqs_p=2 queue full with ready_i=0 -> ready_o=0; reset asserted mid-stall -> queue drops, v_o=0.

Source files
------------

// File: rtl/bp_lce_req_queued.sv
// LCE request issuer: in-order request queue, late metadata pairing and
// credit-limited issue of LCE->CCE requests, with an uncached LCE mode.

package bp_lce_req_queued_pkg;

  localparam int paddr_width_lp  = 32;
  localparam int lce_id_width_lp = 4;
  localparam int cce_id_width_lp = 2;
  localparam int way_id_width_lp = 3;
  localparam int data_width_lp   = 64;

  typedef enum logic [1:0] {
    e_lce_mode_uncached = 2'd0,
    e_lce_mode_normal   = 2'd1,
    e_lce_mode_nonspec  = 2'd2
  } bp_lce_mode_e;

  typedef enum logic [1:0] {
    e_miss_load  = 2'd0,
    e_miss_store = 2'd1,
    e_uc_load    = 2'd2,
    e_uc_store   = 2'd3
  } bp_cache_req_msg_type_e;

  // Encoded as log2 of the byte count
  typedef enum logic [2:0] {
    e_size_1   = 3'd0,
    e_size_2   = 3'd1,
    e_size_4   = 3'd2,
    e_size_8   = 3'd3,
    e_size_16  = 3'd4,
    e_size_32  = 3'd5,
    e_size_64  = 3'd6,
    e_size_128 = 3'd7
  } bp_mem_msg_size_e;

  typedef struct packed {
    bp_cache_req_msg_type_e     msg_type;
    bp_mem_msg_size_e           size;
    logic [paddr_width_lp-1:0]  addr;
    logic [data_width_lp-1:0]   data;
  } bp_cache_req_s;

  typedef struct packed {
    logic [way_id_width_lp-1:0] hit_or_repl_way;
  } bp_cache_req_metadata_s;

  typedef enum logic [1:0] {
    e_lce_req_type_rd    = 2'd0,
    e_lce_req_type_wr    = 2'd1,
    e_lce_req_type_uc_rd = 2'd2,
    e_lce_req_type_uc_wr = 2'd3
  } bp_lce_cce_req_type_e;

  typedef struct packed {
    bp_lce_cce_req_type_e        msg_type;
    logic                        non_excl;
    bp_mem_msg_size_e            size;
    logic [paddr_width_lp-1:0]   addr;
    logic [way_id_width_lp-1:0]  lru_way_id;
    logic [lce_id_width_lp-1:0]  src_id;
    logic [cce_id_width_lp-1:0]  dst_id;
  } bp_lce_cce_req_header_s;

  typedef struct packed {
    bp_lce_cce_req_header_s      header;
    logic [data_width_lp-1:0]    data;
  } bp_lce_cce_req_s;

endpackage

module bp_lce_req_queued
  import bp_lce_req_queued_pkg::*;
#(
  parameter int block_width_p    = 512,
  parameter int reqs_p           = 2,
  parameter int credits_p        = 2,
  parameter bit non_excl_reads_p = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [lce_id_width_lp-1:0]  lce_id_i,
  input  bp_lce_mode_e                lce_mode_i,
  output logic                        ready_o,
  input  bp_cache_req_s               cache_req_i,
  input  logic                        cache_req_v_i,
  input  bp_cache_req_metadata_s      cache_req_metadata_i,
  input  logic                        cache_req_metadata_v_i,
  output logic                        credits_full_o,
  output logic                        credits_empty_o,
  input  logic                        cache_req_complete_i,
  input  logic                        uc_store_req_complete_i,
  output bp_lce_cce_req_s             lce_req_o,
  output logic                        lce_req_v_o,
  input  logic                        lce_req_ready_i
);

  localparam int block_offset_lp = $clog2(block_width_p / 8);
  localparam bp_mem_msg_size_e block_size_lp = bp_mem_msg_size_e'(3'(block_offset_lp));
  localparam int ptr_width_lp  = (reqs_p > 1) ? $clog2(reqs_p) : 1;
  localparam int qcnt_width_lp = $clog2(reqs_p + 1);
  localparam int cred_width_lp = $clog2(credits_p + 1);
  localparam int csum_width_lp = cred_width_lp + 1;

  typedef enum logic [1:0] {
    e_reset       = 2'd0,
    e_ready       = 2'd1,
    e_wait_meta   = 2'd2,
    e_wait_credit = 2'd3
  } state_e;

  state_e state_reg, state_next;

  bp_cache_req_s               req_mem_reg [reqs_p];
  logic [way_id_width_lp-1:0]  way_mem_reg [reqs_p];
  logic [reqs_p-1:0]           uc_mem_reg;
  logic [reqs_p-1:0]           meta_v_reg;

  logic [ptr_width_lp-1:0]     head_ptr_reg, tail_ptr_reg, last_ptr_reg;
  logic [qcnt_width_lp-1:0]    q_count_reg;
  logic                        awaiting_meta_reg;
  logic [cred_width_lp-1:0]    credit_count_reg, credit_count_next;

  logic enq, deq, new_uc, new_needs_meta, head_valid, head_meta_missing;
  logic [csum_width_lp-1:0] credit_add, credit_ret;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(reqs_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign enq = ready_o & cache_req_v_i;
  assign deq = lce_req_v_o & lce_req_ready_i;

  // Uncached mode is captured per entry so a later mode change cannot alter a queued request
  assign new_uc         = (lce_mode_i == e_lce_mode_uncached);
  assign new_needs_meta = ~new_uc & ((cache_req_i.msg_type == e_miss_load)
                                   | (cache_req_i.msg_type == e_miss_store));

  assign head_valid        = (q_count_reg != '0);
  assign head_meta_missing = ~meta_v_reg[head_ptr_reg];

  // No bypass: a full queue blocks enqueue even in a dequeue cycle
  assign ready_o = reset_n_i & (state_reg != e_reset)
                 & (q_count_reg != qcnt_width_lp'(reqs_p)) & ~awaiting_meta_reg;

  always_ff @(posedge clk_i) begin
    if (enq) begin
      req_mem_reg[tail_ptr_reg] <= cache_req_i;
      uc_mem_reg[tail_ptr_reg]  <= new_uc;
      way_mem_reg[tail_ptr_reg] <= cache_req_metadata_i.hit_or_repl_way;
    end else if (cache_req_metadata_v_i & awaiting_meta_reg) begin
      way_mem_reg[last_ptr_reg] <= cache_req_metadata_i.hit_or_repl_way;
    end
  end

  // Only the newest entry can be missing metadata, because enqueue stalls while it is
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      head_ptr_reg      <= '0;
      tail_ptr_reg      <= '0;
      last_ptr_reg      <= '0;
      q_count_reg       <= '0;
      meta_v_reg        <= '0;
      awaiting_meta_reg <= 1'b0;
    end else begin
      if (enq) begin
        tail_ptr_reg             <= ptr_inc(tail_ptr_reg);
        last_ptr_reg             <= tail_ptr_reg;
        meta_v_reg[tail_ptr_reg] <= ~new_needs_meta | cache_req_metadata_v_i;
        awaiting_meta_reg        <= new_needs_meta & ~cache_req_metadata_v_i;
      end else if (cache_req_metadata_v_i & awaiting_meta_reg) begin
        meta_v_reg[last_ptr_reg] <= 1'b1;
        awaiting_meta_reg        <= 1'b0;
      end
      if (deq) begin
        head_ptr_reg <= ptr_inc(head_ptr_reg);
      end
      q_count_reg <= q_count_reg + qcnt_width_lp'(enq) - qcnt_width_lp'(deq);
    end
  end

  assign credit_add = csum_width_lp'(credit_count_reg) + csum_width_lp'(deq);
  assign credit_ret = csum_width_lp'(cache_req_complete_i) + csum_width_lp'(uc_store_req_complete_i);
  assign credit_count_next = (credit_add < credit_ret) ? '0
                           : cred_width_lp'(credit_add - credit_ret);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      credit_count_reg <= '0;
    end else begin
      assert (credit_add >= credit_ret);
      credit_count_reg <= credit_count_next;
    end
  end

  assign credits_full_o  = (credit_count_reg == cred_width_lp'(credits_p));
  assign credits_empty_o = (credit_count_reg == '0);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_reg <= e_reset;
    end else begin
      state_reg <= state_next;
    end
  end

  // Valid depends only on state, head and credits, so it holds until the handshake
  always_comb begin
    state_next  = state_reg;
    lce_req_v_o = 1'b0;
    unique case (state_reg)
      e_reset: state_next = e_ready;
      e_ready: begin
        if (head_valid & head_meta_missing) begin
          state_next = e_wait_meta;
        end else if (credits_full_o) begin
          state_next = e_wait_credit;
        end else begin
          lce_req_v_o = head_valid & reset_n_i;
        end
      end
      e_wait_meta: begin
        if (~head_meta_missing | (cache_req_metadata_v_i & awaiting_meta_reg)) begin
          state_next = e_ready;
        end
      end
      e_wait_credit: begin
        if (~credits_full_o) begin
          state_next = e_ready;
        end
      end
      default: state_next = e_reset;
    endcase
  end

  always_comb begin
    bp_cache_req_s head_req;
    logic          head_uc, head_cached, head_load;
    head_req    = req_mem_reg[head_ptr_reg];
    head_uc     = uc_mem_reg[head_ptr_reg];
    head_load   = (head_req.msg_type == e_miss_load) | (head_req.msg_type == e_uc_load);
    head_cached = ~head_uc & ((head_req.msg_type == e_miss_load)
                            | (head_req.msg_type == e_miss_store));

    lce_req_o               = '0;
    lce_req_o.header.src_id = lce_id_i;
    lce_req_o.header.dst_id = head_req.addr[block_offset_lp +: cce_id_width_lp];
    lce_req_o.header.addr   = head_req.addr;
    if (head_cached) begin
      lce_req_o.header.size       = block_size_lp;
      lce_req_o.header.lru_way_id = way_mem_reg[head_ptr_reg];
      if (head_load) begin
        lce_req_o.header.msg_type = e_lce_req_type_rd;
        lce_req_o.header.non_excl = non_excl_reads_p;
      end else begin
        lce_req_o.header.msg_type = e_lce_req_type_wr;
      end
    end else begin
      lce_req_o.header.size = head_req.size;
      if (head_load) begin
        lce_req_o.header.msg_type = e_lce_req_type_uc_rd;
      end else begin
        lce_req_o.header.msg_type = e_lce_req_type_uc_wr;
        lce_req_o.data            = head_req.data;
      end
    end
  end

endmodule

// File: tb/tb_bp_lce_req_queued.sv
// Directed plus randomized bench for bp_lce_req_queued, checked against a
// transaction-level queue/credit model.
`timescale 1ns/1ps
module tb_bp_lce_req_queued;
  import bp_lce_req_queued_pkg::*;

  localparam int CREDITS  = 2;
  localparam int REQS     = 2;
  localparam int LCE_ID   = 5;
  localparam bit NON_EXCL = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset_n_i;
  logic [3:0]              lce_id_i;
  bp_lce_mode_e            lce_mode_i;
  logic                    ready_o;
  bp_cache_req_s           cache_req_i;
  logic                    cache_req_v_i;
  bp_cache_req_metadata_s  cache_req_metadata_i;
  logic                    cache_req_metadata_v_i;
  logic                    credits_full_o, credits_empty_o;
  logic                    cache_req_complete_i, uc_store_req_complete_i;
  bp_lce_cce_req_s         lce_req_o;
  logic                    lce_req_v_o;
  logic                    lce_req_ready_i;

  bp_lce_req_queued #(
    .block_width_p(512), .reqs_p(REQS), .credits_p(CREDITS), .non_excl_reads_p(NON_EXCL)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .lce_id_i(lce_id_i), .lce_mode_i(lce_mode_i),
    .ready_o(ready_o), .cache_req_i(cache_req_i), .cache_req_v_i(cache_req_v_i),
    .cache_req_metadata_i(cache_req_metadata_i), .cache_req_metadata_v_i(cache_req_metadata_v_i),
    .credits_full_o(credits_full_o), .credits_empty_o(credits_empty_o),
    .cache_req_complete_i(cache_req_complete_i), .uc_store_req_complete_i(uc_store_req_complete_i),
    .lce_req_o(lce_req_o), .lce_req_v_o(lce_req_v_o), .lce_req_ready_i(lce_req_ready_i)
  );

  int checks = 0;
  int failures = 0;
  bp_lce_cce_req_s exp_q[$];
  int model_credits = 0;
  int sent = 0;
  logic hold_prev = 1'b0;
  bp_lce_cce_req_s hdr_prev;
  logic [2:0] cur_way = 3'd0;
  logic last_acc = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected LCE request for an accepted cache request, straight from the header rules
  function automatic bp_lce_cce_req_s exp_msg(input bp_cache_req_s r, input logic uc,
                                              input logic [2:0] way);
    bp_lce_cce_req_s m;
    bit is_load, is_miss;
    is_load = (r.msg_type == e_miss_load) || (r.msg_type == e_uc_load);
    is_miss = (r.msg_type == e_miss_load) || (r.msg_type == e_miss_store);
    m = '0;
    m.header.src_id = 4'(LCE_ID);
    m.header.dst_id = 2'((r.addr / 64) % 4);
    m.header.addr   = r.addr;
    if (is_miss && !uc) begin
      m.header.size       = e_size_64;
      m.header.lru_way_id = way;
      m.header.msg_type   = is_load ? e_lce_req_type_rd : e_lce_req_type_wr;
      m.header.non_excl   = is_load && NON_EXCL;
    end else begin
      m.header.size     = r.size;
      m.header.msg_type = is_load ? e_lce_req_type_uc_rd : e_lce_req_type_uc_wr;
      if (!is_load) m.data = r.data;
    end
    return m;
  endfunction

  // One clock: check outputs, record handshakes, advance the model, return at negedge
  task automatic cyc();
    logic acc, snd, rst_now;
    bp_lce_cce_req_s m;
    #1;
    if (reset_n_i) begin
      if (lce_req_v_o) begin
        chk1("v_has_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chkw("lce_req", 128'(lce_req_o), 128'(exp_q[0]));
      end
      if (hold_prev) begin
        chk1("hold_v", lce_req_v_o, 1'b1);
        if (lce_req_v_o) chkw("hold_hdr", 128'(lce_req_o), 128'(hdr_prev));
      end
      chk1("credits_full", credits_full_o, model_credits == CREDITS);
      chk1("credits_empty", credits_empty_o, model_credits == 0);
      if (model_credits == CREDITS) chk1("v_at_full", lce_req_v_o, 1'b0);
    end
    acc       = ready_o & cache_req_v_i;
    snd       = lce_req_v_o & lce_req_ready_i;
    rst_now   = !reset_n_i;
    hold_prev = lce_req_v_o & !lce_req_ready_i & reset_n_i;
    hdr_prev  = lce_req_o;
    last_acc  = acc;
    m = exp_msg(cache_req_i, lce_mode_i == e_lce_mode_uncached, cur_way);
    @(posedge clk);
    if (rst_now) begin
      exp_q.delete();
      model_credits = 0;
      hold_prev = 1'b0;
    end else begin
      if (snd && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        sent++;
      end
      if (acc) exp_q.push_back(m);
      model_credits += (snd ? 1 : 0) - int'(cache_req_complete_i) - int'(uc_store_req_complete_i);
      if (model_credits < 0) model_credits = 0;
    end
    @(negedge clk);
  endtask

  task automatic push_req(input bp_cache_req_msg_type_e t, input logic [31:0] a,
                          input bp_mem_msg_size_e s, input logic [63:0] d);
    cache_req_i.msg_type = t;
    cache_req_i.addr     = a;
    cache_req_i.size     = s;
    cache_req_i.data     = d;
    cache_req_v_i        = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (last_acc) break;
    end
    cache_req_v_i = 1'b0;
    chk1("accept_timeout", last_acc, 1'b1);
    $display("req type=%0d addr=%08h accepted=%0b", t, a, last_acc);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
    chk1(tag, exp_q.size() == 0, 1'b1);
  endtask

  initial begin
    int s0, meta_delay;
    bit req_pending, meta_with_req, meta_now;
    reset_n_i = 1'b0; lce_id_i = 4'(LCE_ID); lce_mode_i = e_lce_mode_normal;
    cache_req_i = '0; cache_req_v_i = 1'b0; cache_req_metadata_i = '0;
    cache_req_metadata_v_i = 1'b0; cache_req_complete_i = 1'b0;
    uc_store_req_complete_i = 1'b0; lce_req_ready_i = 1'b1;
    @(negedge clk);

    // 1: reset behaviour and release latency
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk1("t1_ready_rst", ready_o, 1'b0);
      chk1("t1_v_rst", lce_req_v_o, 1'b0);
      chk1("t1_empty_rst", credits_empty_o, 1'b1);
      chk1("t1_full_rst", credits_full_o, 1'b0);
    end
    reset_n_i = 1'b1;
    #1 chk1("t1_ready_first", ready_o, 1'b0);
    cyc();
    chk1("t1_ready_second", ready_o, 1'b1);

    // 2: cached miss load, metadata two cycles later
    cur_way = 3'd3;
    push_req(e_miss_load, 32'h8000_0040, e_size_8, 64'h0);
    chk1("t2_ready_wait_meta", ready_o, 1'b0);
    chk1("t2_v_before_meta", lce_req_v_o, 1'b0);
    cyc();
    chk1("t2_v_wait_meta", lce_req_v_o, 1'b0);
    cache_req_metadata_i.hit_or_repl_way = 3'd3;
    cache_req_metadata_v_i = 1'b1;
    cyc();
    cache_req_metadata_v_i = 1'b0;
    chk1("t2_v_after_meta", lce_req_v_o, 1'b1);
    chkw("t2_type", 128'(lce_req_o.header.msg_type), 128'(e_lce_req_type_rd));
    chk1("t2_excl", lce_req_o.header.non_excl, 1'b0);
    chkw("t2_way", 128'(lce_req_o.header.lru_way_id), 128'(3));
    chkw("t2_size", 128'(lce_req_o.header.size), 128'(e_size_64));
    cyc();
    chk1("t2_count_one", credits_empty_o, 1'b0);
    cache_req_complete_i = 1'b1; cyc(); cache_req_complete_i = 1'b0;
    chk1("t2_count_zero", credits_empty_o, 1'b1);

    // 3: credit limit with three back-to-back uncached loads
    s0 = sent;
    for (int k = 0; k < 3; k++) push_req(e_uc_load, 32'h0000_1000 + 32'(k * 64), e_size_8, 64'h0);
    cyc(); cyc();
    chk1("t3_full", credits_full_o, 1'b1);
    chk1("t3_v_held", lce_req_v_o, 1'b0);
    chkw("t3_sent_two", 128'(sent - s0), 128'(2));
    cache_req_complete_i = 1'b1; cyc(); cache_req_complete_i = 1'b0;
    wait_drain("t3_third_sent");
    chkw("t3_sent_three", 128'(sent - s0), 128'(3));
    cache_req_complete_i = 1'b1; cyc(); cyc(); cache_req_complete_i = 1'b0;
    chk1("t3_empty", credits_empty_o, 1'b1);

    // 4: uncached store held under back-pressure
    lce_req_ready_i = 1'b0;
    s0 = sent;
    push_req(e_uc_store, 32'h1000_0080, e_size_4, 64'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) cyc();
    chk1("t4_v_held", lce_req_v_o, 1'b1);
    chkw("t4_type", 128'(lce_req_o.header.msg_type), 128'(e_lce_req_type_uc_wr));
    chkw("t4_data", 128'(lce_req_o.data), 128'(64'hDEAD_BEEF));
    chkw("t4_size", 128'(lce_req_o.header.size), 128'(e_size_4));
    lce_req_ready_i = 1'b1;
    cyc();
    chkw("t4_one_send", 128'(sent - s0), 128'(1));
    chk1("t4_v_done", lce_req_v_o, 1'b0);
    uc_store_req_complete_i = 1'b1; cyc(); uc_store_req_complete_i = 1'b0;

    // 5: uncached mode converts misses; double return at count 2
    lce_mode_i = e_lce_mode_uncached;
    push_req(e_miss_store, 32'h2000_01C0, e_size_8, 64'h0123_4567_89AB_CDEF);
    chk1("t5_ready_no_meta", ready_o, 1'b1);
    chk1("t5_v", lce_req_v_o, 1'b1);
    chkw("t5_type", 128'(lce_req_o.header.msg_type), 128'(e_lce_req_type_uc_wr));
    chkw("t5_data", 128'(lce_req_o.data), 128'(64'h0123_4567_89AB_CDEF));
    push_req(e_miss_load, 32'h2000_0200, e_size_2, 64'h0);
    wait_drain("t5_drain");
    lce_mode_i = e_lce_mode_normal;
    chk1("t5_full", credits_full_o, 1'b1);
    cache_req_complete_i = 1'b1; uc_store_req_complete_i = 1'b1;
    cyc();
    cache_req_complete_i = 1'b0; uc_store_req_complete_i = 1'b0;
    chk1("t5_empty", credits_empty_o, 1'b1);
    chk1("t5_not_full", credits_full_o, 1'b0);

    // 6: full queue stalled, then reset drops it
    lce_req_ready_i = 1'b0;
    push_req(e_uc_load, 32'h3000_0000, e_size_8, 64'h0);
    push_req(e_uc_load, 32'h3000_0040, e_size_8, 64'h0);
    chk1("t6_ready_full", ready_o, 1'b0);
    chk1("t6_v_stall", lce_req_v_o, 1'b1);
    reset_n_i = 1'b0;
    cyc();
    chk1("t6_v_reset", lce_req_v_o, 1'b0);
    chk1("t6_ready_reset", ready_o, 1'b0);
    reset_n_i = 1'b1;
    lce_req_ready_i = 1'b1;
    cyc(); cyc();
    chk1("t6_ready_after", ready_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk1("t6_dropped", lce_req_v_o, 1'b0);
    end

    // Randomized traffic against the model
    s0 = sent; meta_delay = -1; req_pending = 0; meta_with_req = 0;
    for (int n = 0; n < 400; n++) begin
      cache_req_metadata_v_i = 1'b0;
      cache_req_complete_i = 1'b0;
      uc_store_req_complete_i = 1'b0;
      meta_now = (meta_delay == 0);
      if (!req_pending && meta_delay < 0 && $urandom_range(1, 0) == 1) begin
        cache_req_i.msg_type = bp_cache_req_msg_type_e'($urandom_range(3, 0));
        cache_req_i.addr = $urandom;
        cache_req_i.size = bp_mem_msg_size_e'($urandom_range(3, 0));
        cache_req_i.data = {$urandom, $urandom};
        lce_mode_i = ($urandom_range(3, 0) == 0) ? e_lce_mode_uncached : e_lce_mode_normal;
        cur_way = 3'($urandom_range(7, 0));
        meta_with_req = ($urandom_range(3, 0) == 0);
        cache_req_v_i = 1'b1;
        req_pending = 1;
      end
      cache_req_metadata_i.hit_or_repl_way = cur_way;
      if ((req_pending && meta_with_req) || meta_now) cache_req_metadata_v_i = 1'b1;
      if (meta_now) meta_delay = -1;
      else if (meta_delay > 0) meta_delay--;
      lce_req_ready_i = ($urandom_range(3, 0) != 0);
      if (model_credits >= 1 && $urandom_range(2, 0) == 0) cache_req_complete_i = 1'b1;
      if (model_credits - int'(cache_req_complete_i) >= 1 && $urandom_range(3, 0) == 0)
        uc_store_req_complete_i = 1'b1;
      cyc();
      if (req_pending && last_acc) begin
        $display("rand req type=%0d addr=%08h mode=%0d way=%0d", cache_req_i.msg_type,
                 cache_req_i.addr, lce_mode_i, cur_way);
        req_pending = 0;
        cache_req_v_i = 1'b0;
        if (lce_mode_i != e_lce_mode_uncached && !meta_with_req &&
            (cache_req_i.msg_type == e_miss_load || cache_req_i.msg_type == e_miss_store))
          meta_delay = $urandom_range(2, 0);
      end
    end
    cache_req_v_i = 1'b0;
    cache_req_metadata_v_i = 1'b0;
    cache_req_complete_i = 1'b0;
    uc_store_req_complete_i = 1'b0;
    if (meta_delay >= 0) begin
      cache_req_metadata_v_i = 1'b1; cyc(); cache_req_metadata_v_i = 1'b0;
    end
    lce_req_ready_i = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      if (model_credits == CREDITS) cache_req_complete_i = 1'b1;
      cyc();
      cache_req_complete_i = 1'b0;
    end
    chk1("rand_drain", exp_q.size() == 0, 1'b1);
    chk1("rand_sent_some", (sent - s0) > 0, 1'b1);
    for (int i = 0; i < 10 && model_credits > 0; i++) begin
      cache_req_complete_i = 1'b1; cyc();
    end
    cache_req_complete_i = 1'b0;
    cyc();
    chk1("rand_final_empty", credits_empty_o, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
